uart_fifo_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/baud_counter.sv | 31 +++
 rtl/uart_fifo_tx.sv | 133 +++++++++++++
 tb/tb_uart_fifo_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud helper
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int bit_rate);
    return clk_freq / bit_rate;
  endfunction

endpackage

// File: rtl/baud_counter.sv
// rtl/baud_counter.sv - bit-period counter, tick on the last clock of each period
module baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - UART transmitter popping bytes from a synchronous FIFO
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BIT_RATE = 115_200,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_read_data_i,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BIT_RATE);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  tx_state_t        state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [IDX_W-1:0] bit_idx;
  logic             baud_clr;
  logic             baud_en;
  logic             baud_tick;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  assign shift_next = shift_reg >> 1;
  assign baud_clr   = (state == LOAD);
`ifdef UART_TX_PARITY_EN
  assign baud_en = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
`else
  assign baud_en = (state == START) || (state == DATA) || (state == STOP);
`endif

  baud_counter #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .en  (baud_en),
    .tick(baud_tick)
  );

  // Outputs are set on the transition into a state so they are valid for that state's whole duration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tx_o         <= 1'b1;
      fifo_rd_en_o <= 1'b0;
      busy_o       <= 1'b0;
      shift_reg    <= '0;
      bit_idx      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit   <= 1'b0;
`endif
    end else begin
      fifo_rd_en_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i && !fifo_empty_i) begin
            state        <= FETCH;
            fifo_rd_en_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        FETCH: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg  <= fifo_read_data_i;
          bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_read_data_i;
`endif
          tx_o       <= 1'b0;
          state      <= START;
        end
        START: begin
          if (baud_tick) begin
            tx_o  <= shift_reg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            shift_reg <= shift_next;
            if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              tx_o  <= parity_bit;
              state <= PARITY;
`else
              tx_o  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_o    <= shift_next[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            tx_o  <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          tx_o   <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb/tb_uart_fifo_tx.sv - directed self-checking bench for uart_fifo_tx
module tb_uart_fifo_tx;

  localparam int CPB = 10;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rdata;
  logic       tx;
  logic       busy;

  logic [7:0] mem [0:63];
  int         wr_ptr;
  int         rd_ptr;
  int         rd_cnt;
  int         empty_pops;
  int         n_checks;
  int         n_fail;

  uart_fifo_tx #(
    .CLK_FREQ(1_000_000),
    .BIT_RATE(100_000),
    .WIDTH   (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable_i        (enable),
    .fifo_empty_i    (fifo_empty),
    .fifo_rd_en_o    (fifo_rd_en),
    .fifo_read_data_i(fifo_rdata),
    .tx_o            (tx),
    .busy_o          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty = (rd_ptr == wr_ptr);

  initial begin
    rd_ptr     = 0;
    fifo_rdata = 8'h00;
  end

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= mem[rd_ptr[5:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  initial begin
    rd_cnt     = 0;
    empty_pops = 0;
  end

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (fifo_empty) empty_pops = empty_pops + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[5:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_start(input int max, output int waited);
    waited = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        waited = i;
        break;
      end
    end
  endtask

  // Called on the first low cycle of the start bit; checks the rest of the frame cycle by cycle.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    int cnt;
    cnt = 1;
    for (int i = 1; i < CPB; i++) begin
      @(negedge clk);
      if (tx === 1'b0) cnt++;
    end
    check({tag, " start"}, cnt, CPB);
    for (int k = 0; k < 8; k++) begin
      cnt = 0;
      for (int i = 0; i < CPB; i++) begin
        @(negedge clk);
        if (tx === b[k]) cnt++;
      end
      check($sformatf("%s bit%0d", tag, k), cnt, CPB);
    end
`ifdef UART_TX_PARITY_EN
    cnt = 0;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (tx === ^b) cnt++;
    end
    check({tag, " parity"}, cnt, CPB);
`endif
    cnt = 0;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (tx === 1'b1 && busy === 1'b1) cnt++;
    end
    check({tag, " stop"}, cnt, CPB);
  endtask

  initial begin
    int w;
    int viol;
    int rd0;
    n_checks = 0;
    n_fail   = 0;
    wr_ptr   = 0;
    rst      = 1'b1;
    enable   = 1'b0;

    // Reset with a non-empty FIFO and enable high
    push(8'h55);
    enable = 1'b1;
    viol = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) viol++;
    end
    check("reset outputs", viol, 0);
    rd0 = rd_cnt;
    rst = 1'b0;
    wait_start(20, w);
    check("reset to start latency", w, 3);
    enable = 1'b0;
    expect_frame(8'h55, "f55");
    @(negedge clk);
    check("f55 idle after stop", {30'd0, tx, busy}, 2);
    check("f55 rd pulses", rd_cnt - rd0, 1);

    // Back-to-back frames
    rd0 = rd_cnt;
    push(8'hA3);
    push(8'h0F);
    enable = 1'b1;
    wait_start(20, w);
    check("fA3 latency", w, 3);
    expect_frame(8'hA3, "fA3");
    wait_start(20, w);
    check("b2b idle gap", w - 1, 3);
    expect_frame(8'h0F, "f0F");
    enable = 1'b0;
    @(negedge clk);
    check("b2b rd pulses", rd_cnt - rd0, 2);

    // Empty FIFO with enable held high
    enable = 1'b1;
    rd0 = rd_cnt;
    viol = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("empty fifo line idle", viol, 0);
    check("empty fifo rd pulses", rd_cnt - rd0, 0);

    // Reset at cycle 40 of a 0xFF frame
    push(8'hFF);
    wait_start(20, w);
    check("fFF latency", w, 3);
    repeat (39) @(negedge clk);
    check("fFF busy mid frame", {31'd0, busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset tx/busy/rd", {29'd0, tx, busy, fifo_rd_en}, 4);
    rst = 1'b0;
    viol = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("no frame after reset", viol, 0);

    // Reset while the start bit is driving the line low
    push(8'h00);
    wait_start(20, w);
    check("f00 latency", w, 3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("reset in start tx/busy", {30'd0, tx, busy}, 2);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);

`ifdef UART_TX_PARITY_EN
    enable = 1'b1;
    push(8'h07);
    wait_start(20, w);
    check("f07 latency", w, 3);
    expect_frame(8'h07, "f07");
    push(8'h03);
    wait_start(20, w);
    check("f03 gap", w - 1, 3);
    expect_frame(8'h03, "f03");
    enable = 1'b0;
    @(negedge clk);
`endif

    check("pops from empty fifo", empty_pops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
